// File: rtl/seq_divider_16x8_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_div_pkg
//  Purpose  : Shared widths, FSM state type and seven-segment glyphs for the
//             16x8 sequential restoring divider.
//  Options  : SEQ_DIV_SEG7_EN enables the seven-segment status outputs.
//  Revision : 1.0  initial release
// ============================================================================
package seq_div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;

    // Counter value of the final quotient-bit iteration.
    localparam logic [3:0] ITER_LAST = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Status codes fed to the segment decoder.
    localparam logic [3:0] SEG_CODE_IDLE = 4'h0;
    localparam logic [3:0] SEG_CODE_CALC = 4'h1;
    localparam logic [3:0] SEG_CODE_DONE = 4'h2;
    localparam logic [3:0] SEG_CODE_ERR  = 4'hE;

    // Glyphs, bit order {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_GLYPH_0   = 7'b1111110;
    localparam logic [6:0] SEG_GLYPH_1   = 7'b0110000;
    localparam logic [6:0] SEG_GLYPH_2   = 7'b1101101;
    localparam logic [6:0] SEG_GLYPH_E   = 7'b1001111;
    localparam logic [6:0] SEG_GLYPH_OFF = 7'b0000000;

endpackage
`default_nettype wire

// File: rtl/seq_divider_16x8_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider_16x8_if
//  Purpose  : Start/done handshake and operand/result bus of the divider.
//             master = requester, slave = divider.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_divider_16x8_if;
    import seq_div_pkg::*;

    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  done;
    logic                  div_by_zero;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;

    modport master (
        output start, dividend, divisor,
        input  done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output done, div_by_zero, quotient, remainder
    );
endinterface
`default_nettype wire

// File: rtl/seq_divider_16x8_seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : div_seg7_decoder
//  Purpose  : Combinational 4-bit status code to seven-segment glyph.
//             Only built when SEQ_DIV_SEG7_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`ifdef SEQ_DIV_SEG7_EN
module div_seg7_decoder
    import seq_div_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    // Map each status code to its glyph; unknown codes blank the display.
    always_comb begin
        seg_o = SEG_GLYPH_OFF;
        case (code_i)
            SEG_CODE_IDLE: seg_o = SEG_GLYPH_0;
            SEG_CODE_CALC: seg_o = SEG_GLYPH_1;
            SEG_CODE_DONE: seg_o = SEG_GLYPH_2;
            SEG_CODE_ERR:  seg_o = SEG_GLYPH_E;
            default:       seg_o = SEG_GLYPH_OFF;
        endcase
    end

endmodule
`endif
`default_nettype wire

// File: rtl/seq_divider_16x8.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider_16x8
//  Purpose  : 16-by-8 unsigned restoring divider, one quotient bit per clock,
//             start/done handshake. Divide by zero returns all-ones and flags
//             div_by_zero one cycle after the accept edge.
//  Options  : SEQ_DIV_SEG7_EN adds seg_a..seg_g status outputs.
//  Revision : 1.0  initial release
// ============================================================================
module seq_divider_16x8
    import seq_div_pkg::*;
(
    input  logic              clk,
    input  logic              reset_a,
    seq_divider_16x8_if.slave bus
`ifdef SEQ_DIV_SEG7_EN
    ,
    output logic              seg_a,
    output logic              seg_b,
    output logic              seg_c,
    output logic              seg_d,
    output logic              seg_e,
    output logic              seg_f,
    output logic              seg_g
`endif
);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q,   cnt_d;
    logic [DIVISOR_W:0]    pr_q,    pr_d;
    logic [DIVIDEND_W-1:0] q_q,     q_d;
    logic [DIVISOR_W-1:0]  dvsr_q,  dvsr_d;
    logic                  done_q,  done_d;
    logic                  dz_q,    dz_d;
    logic [DIVIDEND_W-1:0] quot_q,  quot_d;
    logic [DIVISOR_W-1:0]  rem_q,   rem_d;

    logic                  w_accept;
    logic                  w_ge;
    logic [DIVISOR_W:0]    w_trial;
    logic [DIVISOR_W:0]    w_diff;

    // A new operation is only taken when idle or once a result is showing;
    // in DONE with done still low the divide-by-zero result is being posted.
    assign w_accept = bus.start &&
                      ((state_q == IDLE) || ((state_q == DONE) && done_q));

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    // PR[8] is always 0; if it were set the subtraction would be due anyway.
    assign w_trial = {pr_q[DIVISOR_W-1:0], q_q[DIVIDEND_W-1]};
    assign w_ge    = pr_q[DIVISOR_W] | (w_trial >= {1'b0, dvsr_q});
    assign w_diff  = w_trial - {1'b0, dvsr_q};

    // Next-state, iteration and result logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        done_d  = done_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE, DONE: begin
                if (w_accept) begin
                    dvsr_d  = bus.divisor;
                    pr_d    = '0;
                    q_d     = bus.dividend;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    dz_d    = 1'b0;
                    state_d = (bus.divisor == '0) ? DONE : CALC;
                end else if ((state_q == DONE) && !done_q) begin
                    done_d = 1'b1;
                    dz_d   = 1'b1;
                    quot_d = '1;
                    rem_d  = '1;
                end
            end
            CALC: begin
                pr_d  = w_ge ? w_diff : w_trial;
                q_d   = {q_q[DIVIDEND_W-2:0], w_ge};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == ITER_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    quot_d  = {q_q[DIVIDEND_W-2:0], w_ge};
                    rem_d   = w_ge ? w_diff[DIVISOR_W-1:0] : w_trial[DIVISOR_W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and output registers; reset aborts any operation.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;

`ifdef SEQ_DIV_SEG7_EN
    logic [3:0] code_q, code_d;
    logic [6:0] w_seg;

    // Status code follows the state being entered so it changes with done.
    always_comb begin
        code_d = SEG_CODE_IDLE;
        if (state_d == CALC)
            code_d = SEG_CODE_CALC;
        else if (state_d == DONE)
            code_d = (dz_d || !done_d) ? SEG_CODE_ERR : SEG_CODE_DONE;
    end

    // Registered status code keeps the segment outputs glitch-free.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a)
            code_q <= SEG_CODE_IDLE;
        else
            code_q <= code_d;
    end

    div_seg7_decoder u_seg7 (
        .code_i (code_q),
        .seg_o  (w_seg)
    );

    assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = w_seg;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_16x8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider_16x8
//  Purpose  : Self-checking bench for seq_divider_16x8: directed cases with
//             literal expectations plus randomized traffic compared every
//             cycle against an arithmetic reference model.
//  Options  : SEQ_DIV_SEG7_EN also checks the segment glyphs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider_16x8;

    logic clk     = 1'b0;
    logic reset_a = 1'b1;

    seq_divider_16x8_if bus ();

`ifdef SEQ_DIV_SEG7_EN
    logic seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
`endif

    seq_divider_16x8 dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus)
`ifdef SEQ_DIV_SEG7_EN
        ,
        .seg_a   (seg_a),
        .seg_b   (seg_b),
        .seg_c   (seg_c),
        .seg_d   (seg_d),
        .seg_e   (seg_e),
        .seg_f   (seg_f),
        .seg_g   (seg_g)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // An operation is a countdown of edges until its precomputed answer
    // appears; while counting down, new requests are ignored.
    int          m_busy = 0;
    bit          m_done = 1'b0;
    bit          m_dz   = 1'b0;
    bit          m_pdz  = 1'b0;
    bit          m_idle = 1'b1;
    logic [15:0] m_q    = '0;
    logic [15:0] m_pq   = '0;
    logic [7:0]  m_r    = '0;
    logic [7:0]  m_pr   = '0;

    always @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            m_busy = 0; m_done = 1'b0; m_dz = 1'b0; m_pdz = 1'b0; m_idle = 1'b1;
            m_q = '0; m_r = '0; m_pq = '0; m_pr = '0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_done = 1'b1; m_dz = m_pdz; m_q = m_pq; m_r = m_pr;
            end
        end else if (bus.start) begin
            m_idle = 1'b0; m_done = 1'b0; m_dz = 1'b0;
            if (bus.divisor == 8'd0) begin
                m_pq = 16'hFFFF; m_pr = 8'hFF; m_pdz = 1'b1; m_busy = 1;
            end else begin
                m_pq   = bus.dividend / {8'd0, bus.divisor};
                m_pr   = 8'(bus.dividend % {8'd0, bus.divisor});
                m_pdz  = 1'b0;
                m_busy = 16;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("done", {31'd0, bus.done}, {31'd0, m_done});
            check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, m_done & m_dz});
            if (m_done || m_idle) begin
                check("quotient", {16'd0, bus.quotient}, {16'd0, m_q});
                check("remainder", {24'd0, bus.remainder}, {24'd0, m_r});
            end
`ifdef SEQ_DIV_SEG7_EN
            begin
                logic [6:0] exp_seg;
                if (m_idle)          exp_seg = 7'b1111110;
                else if (m_busy > 0) exp_seg = m_pdz ? 7'b1001111 : 7'b0110000;
                else                 exp_seg = m_dz  ? 7'b1001111 : 7'b1101101;
                check("segments", {25'd0, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g},
                      {25'd0, exp_seg});
            end
`endif
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er, input bit edz,
                          input int elat);
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check({name, " latency"}, lat, elat);
        check({name, " done"}, {31'd0, bus.done}, 32'd1);
        check({name, " quotient"}, {16'd0, bus.quotient}, {16'd0, eq});
        check({name, " remainder"}, {24'd0, bus.remainder}, {24'd0, er});
        check({name, " div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, edz});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int low;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        #1 reset_a = 1'b0;
        chk_en = 1'b1;
        #1;
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset quotient", {16'd0, bus.quotient}, 32'd0);
        check("reset remainder", {24'd0, bus.remainder}, 32'd0);
        check("reset div_by_zero", {31'd0, bus.div_by_zero}, 32'd0);
        repeat (3) @(negedge clk);
        #2 reset_a = 1'b1;

        run_op("1000/7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16);
        run_op("7839/201", 16'd7839, 8'd201, 16'd39, 8'd0, 1'b0, 16);
        run_op("FFFF/1", 16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, 16);
        run_op("5/9", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 16);

        // Start held in DONE: back-to-back 200/200, done low for 16 cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd200; bus.divisor = 8'd200;
        low = 0;
        @(negedge clk);
        while (!bus.done && low < 40) begin
            low++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("b2b done low cycles", low, 16);
        check("b2b quotient", {16'd0, bus.quotient}, 32'd1);
        check("b2b remainder", {24'd0, bus.remainder}, 32'd0);

        run_op("1234/0", 16'd1234, 8'd0, 16'hFFFF, 8'hFF, 1'b1, 1);

        // Reset in the middle of a calculation.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset_a = 1'b0;
        #1;
        check("midreset done", {31'd0, bus.done}, 32'd0);
        check("midreset quotient", {16'd0, bus.quotient}, 32'd0);
        check("midreset remainder", {24'd0, bus.remainder}, 32'd0);
        @(negedge clk);
        #2 reset_a = 1'b1;
        run_op("100/3", 16'd100, 8'd3, 16'd33, 8'd1, 1'b0, 16);

        // Start and operands toggled during the calculation are ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 8'd7;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.start    = 1'($urandom_range(0, 1));
            bus.dividend = 16'($urandom);
            bus.divisor  = 8'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check("toggle quotient", {16'd0, bus.quotient}, 32'd142);
        check("toggle remainder", {24'd0, bus.remainder}, 32'd6);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.dividend = 16'($urandom);
            if ($urandom_range(0, 7) == 0)
                bus.divisor = 8'd0;
            else if ($urandom_range(0, 3) == 0)
                bus.divisor = 8'($urandom_range(1, 3));
            else
                bus.divisor = 8'($urandom_range(1, 255));
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
